// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types, constants and Sysbus tag builder for bus_arbiter
// Contents: state_t FSM encoding, client indices, line size, build_tag().
`ifndef SYSBUS_READ
`define SYSBUS_READ   1'b1
`endif
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE  1'b0
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

package bus_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        RWAIT = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] CL_IF = 2'd0;
    localparam logic [1:0] CL_DR = 2'd1;
    localparam logic [1:0] CL_DW = 2'd2;

    localparam int LINE_BITS    = 512;
    localparam int SYSBUS_TAG_W = 13;

    // Request tag layout: {direction, target, transaction id}; the id is the
    // client index so response beats can be matched back to their owner.
    function automatic logic [SYSBUS_TAG_W-1:0] build_tag(input logic is_write,
                                                          input logic [1:0] owner);
        return {(is_write ? `SYSBUS_WRITE : `SYSBUS_READ), `SYSBUS_MEMORY, 8'(owner)};
    endfunction

endpackage

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - combinational 3-way round-robin picker (module rr_arbiter3)
// Ports: req[2:0] pending requests, last[1:0] last granted index,
//        grant[2:0] one-hot pick, valid high when any request is pending.
module rr_arbiter3 (
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] grant,
    output logic       valid
);

    // Search starts at the index just after the last winner and wraps 2 -> 0.
    always_comb begin
        grant = 3'b000;
        case (last)
            2'd0: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            2'd1: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

    assign valid = |req;

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - serializes fetch/data-read/writeback line transactions onto Sysbus
// Ports: clk, reset (sync, active-high);
//        Sysbus request side bus_reqcyc/bus_reqack/bus_req/bus_reqtag,
//        Sysbus response side bus_respcyc/bus_respack/bus_resp/bus_resptag;
//        clients if/dr/dw: *_req, *_addr, *_done, dw_line in, if_line/dr_line out.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BEATS     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,

    output logic                                 bus_reqcyc,
    input  logic                                 bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0]            bus_req,
    output logic [BUS_TAG_WIDTH-1:0]             bus_reqtag,

    input  logic                                 bus_respcyc,
    output logic                                 bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0]            bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]             bus_resptag,

    input  logic                                 if_req,
    input  logic                                 dr_req,
    input  logic                                 dw_req,
    input  logic [63:0]                          if_addr,
    input  logic [63:0]                          dr_addr,
    input  logic [63:0]                          dw_addr,
    input  logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] dw_line,

    output logic                                 if_done,
    output logic                                 dr_done,
    output logic                                 dw_done,
    output logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] if_line,
    output logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] dr_line
);

    localparam int LW = BUS_DATA_WIDTH * LINE_BEATS;

    state_t       state_q, state_d;
    logic [2:0]   beat_q, beat_d;
    logic [1:0]   owner_q, owner_d;
    logic [1:0]   last_q, last_d;
    logic [57:0]  addr_q, addr_d;          // line address, offset bits dropped
    logic [LW-1:0] line_buf_q, line_buf_d;

    logic                      reqcyc_d;
    logic [BUS_DATA_WIDTH-1:0] req_d;
    logic [BUS_TAG_WIDTH-1:0]  reqtag_d;
    logic                      if_done_d, dr_done_d, dw_done_d;
    logic [LW-1:0]             if_line_d, dr_line_d;

    logic [2:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       last_beat;
    logic       resp_hit;

    // Low address bits and the tag's direction/target field are not needed here.
    logic unused_bits;
    assign unused_bits = ^{if_addr[5:0], dr_addr[5:0], dw_addr[5:0], bus_resptag[BUS_TAG_WIDTH-1:8]};

    rr_arbiter3 u_rr (
        .req   ({dw_req, dr_req, if_req}),
        .last  (last_q),
        .grant (grant),
        .valid (grant_valid)
    );

    assign grant_idx = grant[2] ? CL_DW : (grant[1] ? CL_DR : CL_IF);
    assign last_beat = (beat_q == 3'(LINE_BEATS - 1));
    assign resp_hit  = bus_respcyc && (bus_resptag[7:0] == 8'(owner_q));

    // Every response beat is accepted while waiting, including ones for other
    // ids, so a stray beat can never stall the bus.
    assign bus_respack = (state_q == RWAIT) && bus_respcyc;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        owner_d    = owner_q;
        last_d     = last_q;
        addr_d     = addr_q;
        line_buf_d = line_buf_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_idx;
                    case (grant_idx)
                        CL_IF:   addr_d = if_addr[63:6];
                        CL_DR:   addr_d = dr_addr[63:6];
                        default: addr_d = dw_addr[63:6];
                    endcase
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (bus_reqack) begin
                    beat_d  = 3'd0;
                    state_d = (owner_q == CL_DW) ? WDATA : RWAIT;
                end
            end
            WDATA: begin
                beat_d = beat_q + 3'd1;
                if (last_beat) state_d = DONE;
            end
            RWAIT: begin
                if (resp_hit) begin
                    line_buf_d[BUS_DATA_WIDTH*int'(beat_q) +: BUS_DATA_WIDTH] = bus_resp;
                    beat_d = beat_q + 3'd1;
                    if (last_beat) state_d = DONE;
                end
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they can be registered
    // without adding a cycle of latency.
    always_comb begin
        reqcyc_d  = 1'b0;
        req_d     = '0;
        reqtag_d  = '0;
        if_done_d = 1'b0;
        dr_done_d = 1'b0;
        dw_done_d = 1'b0;
        if_line_d = if_line;
        dr_line_d = dr_line;
        case (state_d)
            ADDR: begin
                reqcyc_d = 1'b1;
                req_d    = BUS_DATA_WIDTH'({addr_d, 6'b0});
                reqtag_d = BUS_TAG_WIDTH'(build_tag(owner_d == CL_DW, owner_d));
            end
            WDATA: begin
                reqcyc_d = 1'b1;
                req_d    = dw_line[BUS_DATA_WIDTH*int'(beat_d) +: BUS_DATA_WIDTH];
                reqtag_d = BUS_TAG_WIDTH'(build_tag(1'b1, owner_d));
            end
            DONE: begin
                if_done_d = (owner_d == CL_IF);
                dr_done_d = (owner_d == CL_DR);
                dw_done_d = (owner_d == CL_DW);
                if (owner_d == CL_IF) if_line_d = line_buf_d;
                if (owner_d == CL_DR) dr_line_d = line_buf_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_q     <= 3'd0;
            owner_q    <= CL_IF;
            last_q     <= CL_DW;
            addr_q     <= '0;
            line_buf_q <= '0;
            bus_reqcyc <= 1'b0;
            bus_req    <= '0;
            bus_reqtag <= '0;
            if_done    <= 1'b0;
            dr_done    <= 1'b0;
            dw_done    <= 1'b0;
            if_line    <= '0;
            dr_line    <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            line_buf_q <= line_buf_d;
            bus_reqcyc <= reqcyc_d;
            bus_req    <= req_d;
            bus_reqtag <= reqtag_d;
            if_done    <= if_done_d;
            dr_done    <= dr_done_d;
            dw_done    <= dw_done_d;
            if_line    <= if_line_d;
            dr_line    <= dr_line_d;
        end
    end

endmodule
